// File: rtl/mips_cpu_muldiv_ctrl.sv
// HI/LO owner and multi-cycle sequencer for MULT/MULTU/DIV/DIVU (shift-add multiply, restoring divide).
// Optional MIPS_CPU_MULDIV_FAST_MULT_EN: multiplies complete in a single cycle; divides stay iterative.
module mips_cpu_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_content_i,
    input  logic [WIDTH-1:0] rt_content_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_rem;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        signed_op = ~op_i[0];
        abs_a     = (signed_op && rs_content_i[WIDTH-1]) ? -rs_content_i : rs_content_i;
        abs_b     = (signed_op && rt_content_i[WIDTH-1]) ? -rt_content_i : rt_content_i;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

        div_rem   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_rem >= {1'b0, b_q});
        div_sub   = div_rem[WIDTH-1:0] - b_q;

        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d     = '0;
                    acc_d     = {{WIDTH{1'b0}}, abs_a};
                    b_d       = abs_b;
                    is_div_d  = op_i[1];
                    neg_res_d = signed_op & (rs_content_i[WIDTH-1] ^ rt_content_i[WIDTH-1]);
                    neg_rem_d = signed_op & rs_content_i[WIDTH-1];
                    if (op_i[1]) begin
                        state_d = DIV;
                    end else begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                        acc_d   = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
                        state_d = FIX;
`else
                        state_d = MUL;
`endif
                    end
                end else begin
                    if (mthi_i) hi_d = wdata_i;
                    if (mtlo_i) lo_d = wdata_i;
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            DIV: begin
                acc_d = {(div_ge ? div_sub : div_rem[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Directed bench for mips_cpu_muldiv_ctrl: results, latency, MTHI/MTLO, ignored re-issue and reset abort.
module tb_mips_cpu_muldiv_ctrl;

    localparam int W = 32;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  rs, rt, wdata;
    logic          mthi, mtlo;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_cpu_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .op_i(op),
        .rs_content_i(rs), .rt_content_i(rt), .mthi_i(mthi), .mtlo_i(mtlo),
        .wdata_i(wdata), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        tick();
        start = 1'b0;
    endtask

    // disturb: re-issue start at cycles 5 and 20, and MTHI/MTLO at cycle 8, all of which must be dropped
    task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int expLat, input logic [W-1:0] expHi,
                         input logic [W-1:0] expLo, input bit disturb);
        logic [W-1:0] oldHi, oldLo, midHi, midLo;
        int lat;
        bit overlap;
        oldHi = hi; oldLo = lo; midHi = hi; midLo = lo;
        lat = 0; overlap = 1'b0;
        applyStimulus(o, a, b);
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_lo_e0"}, lo, oldLo);
        for (int n = 1; n <= 40; n++) begin
            if (disturb && (n == 5 || n == 20)) begin
                start = 1'b1; op = 2'b00; rs = 32'h0000_0009; rt = 32'h0000_0003;
            end else if (disturb && n == 8) begin
                start = 1'b0; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_0BAD;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            tick();
            if (n == 16) begin midHi = hi; midLo = lo; end
            if (done && busy) overlap = 1'b1;
            if (done) begin lat = n; break; end
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_hi"}, hi, expHi);
        checkOutput({tag, "_lo"}, lo, expLo);
        checkOutput({tag, "_busy_at_done"}, {63'b0, busy | overlap}, 0);
        if (expLat > 16) begin
            checkOutput({tag, "_hi_mid"}, midHi, oldHi);
            checkOutput({tag, "_lo_mid"}, midLo, oldLo);
        end
        tick();
        checkOutput({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
        wdata = '0; mthi = 1'b0; mtlo = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_1234;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        checkOutput("mthilo_hi", hi, 32'h0000_1234);
        checkOutput("mthilo_lo", lo, 32'h0000_1234);
        mtlo = 1'b1; wdata = 32'h0000_5555;
        tick();
        mtlo = 1'b0;
        checkOutput("mtlo_only_lo", lo, 32'h0000_5555);
        checkOutput("mtlo_only_hi", hi, 32'h0000_1234);

        // mtlo alongside start is dropped; runOp checks lo right after the issue edge
        mtlo = 1'b1; wdata = 32'h0000_9999;
        runOp("multu_2x3", 2'b01, 32'd2, 32'd3, MUL_LAT, 32'h0, 32'h6, 1'b0);

        runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        runOp("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        runOp("multu_wide", 2'b01, 32'h1234_5678, 32'h10, MUL_LAT, 32'h0000_0001, 32'h2345_6780, 1'b0);
        runOp("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runOp("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        runOp("divu_zero", 2'b11, 32'd100, 32'd0, DIV_LAT, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
        runOp("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000, 1'b0);
        runOp("divu_reissue", 2'b11, 32'd1000, 32'd7, DIV_LAT, 32'h6, 32'h8E, 1'b1);

        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7);
        repeat (9) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_lo", lo, 0);
        runOp("after_reset", 2'b01, 32'd6, 32'd7, MUL_LAT, 32'h0, 32'd42, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
